// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the decode-stage hazard tracker: register address width,
// shadow-slot layout and the bubble constant.
// No logic of its own; pure types, constants and a compare helper.
package hazard_tracker_pkg;

    localparam int REG_ADDRESS_LEN = 4;
    localparam int HAZ_SLOT_W      = 6;

    // One in-flight writer as seen from decode.
    typedef struct packed {
        logic                       wb_en;
        logic [REG_ADDRESS_LEN-1:0] dest;
        logic                       mem_read;
    } slot_t;

    // A bubble never matches because wb_en is clear.
    localparam slot_t HAZ_BUBBLE = '0;

    // True when a writer to dest is read by the decode instruction.
    // All sixteen registers are compared; r15 is not special.
    function automatic logic hz_match(
        input logic                       wb_en,
        input logic [REG_ADDRESS_LEN-1:0] dest,
        input logic [REG_ADDRESS_LEN-1:0] src1,
        input logic                       two_src,
        input logic [REG_ADDRESS_LEN-1:0] src2
    );
        return wb_en && ((src1 == dest) || (two_src && (src2 == dest)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge after inc/clear; clear has priority over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Clear first, then increment unless already saturated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Decode-stage data-hazard detector with a two-slot shadow of EX/MEM writers.
// Latency: hazard is combinational from ID inputs; slots and stall count are registered.
// Backpressure: hazard freezes PC and IF/ID and bubbles ID/EX; mem_freeze holds everything.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int FORWARDING = 0,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_ADDRESS_LEN-1:0] src1,
    input  logic                       two_src,
    input  logic [REG_ADDRESS_LEN-1:0] src2,
    input  logic                       id_wb_en,
    input  logic [REG_ADDRESS_LEN-1:0] id_dest,
    input  logic                       id_mem_read,
    input  logic                       branch_taken,
    input  logic                       mem_freeze,
    input  logic                       stat_clear,
    output logic                       hazard,
    output logic                       ex_wb_en,
    output logic [REG_ADDRESS_LEN-1:0] ex_dest,
    output logic                       mem_wb_en,
    output logic [REG_ADDRESS_LEN-1:0] mem_dest,
    output logic [CNT_W-1:0]           stall_count
);

    slot_t ex_slot;
    slot_t ex_next;
    logic  raw;
    logic  ex_match;

    // The MEM copy drops the load flag: once a load leaves EX its data is
    // either forwarded or visible to decode, so only wb_en/dest matter there.
    logic                       mem_wb_en_q;
    logic [REG_ADDRESS_LEN-1:0] mem_dest_q;

    assign ex_match = hz_match(ex_slot.wb_en, ex_slot.dest, src1, two_src, src2);

    generate
        if (FORWARDING != 0) begin : g_fwd
            // Only a load in EX cannot be forwarded in time.
            assign raw = ex_match && ex_slot.mem_read;
        end else begin : g_nofwd
            logic mem_match;
            assign mem_match = hz_match(mem_wb_en_q, mem_dest_q, src1, two_src, src2);
            assign raw       = ex_match || mem_match;
        end
    endgenerate

    // A flushed or empty decode slot never stalls.
    assign hazard = id_valid && !branch_taken && raw;

    // Choose what enters EX: the decode instruction, or a bubble when it is
    // stalled, flushed or not a real instruction.
    always_comb begin
        ex_next = HAZ_BUBBLE;
        if (id_valid && !hazard && !branch_taken) begin
            ex_next.wb_en    = id_wb_en;
            ex_next.dest     = id_dest;
            ex_next.mem_read = id_mem_read;
        end
    end

    // Shadow pipeline: advance EX->MEM and ID->EX unless memory is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_slot     <= HAZ_BUBBLE;
            mem_wb_en_q <= 1'b0;
            mem_dest_q  <= '0;
        end else if (!mem_freeze) begin
            mem_wb_en_q <= ex_slot.wb_en;
            mem_dest_q  <= ex_slot.dest;
            ex_slot     <= ex_next;
        end
    end

    assign ex_wb_en  = ex_slot.wb_en;
    assign ex_dest   = ex_slot.dest;
    assign mem_wb_en = mem_wb_en_q;
    assign mem_dest  = mem_dest_q;

    // Frozen cycles are not counted as stall cycles.
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard && !mem_freeze),
        .clear (stat_clear),
        .count (stall_count)
    );

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Data-hazard detector for the 5-stage ARM pipeline. It takes the decode stage's source-register outputs (`two_src`, second-source address) and the destination/write-enable of the instruction being decoded. It keeps its own two-slot shadow of in-flight writers (EX and MEM), mirroring the ID/EX and EX/MEM registers. From these it raises a same-cycle `hazard` that freezes PC and IF/ID and inserts a bubble into ID/EX. Write-back stage is not tracked: the register file writes before the ID read in the same cycle.

## Interface
Parameters:
- `FORWARDING`, 0 — 0: stall on any EX/MEM writer match; 1: stall only on EX-stage load-use match.
- `CNT_W`, 16 — stall-counter width.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `id_valid` in 1 — ID holds a real instruction (0 = bubble).
- `src1` in `REG_ADDRESS_LEN` (4) — first source register of ID instruction.
- `two_src` in 1 — ID instruction also reads `src2`.
- `src2` in 4 — second source register (`reg_file_second_src_out`).
- `id_wb_en` in 1 — ID instruction writes a register.
- `id_dest` in 4 — its destination.
- `id_mem_read` in 1 — ID instruction is a load.
- `branch_taken` in 1 — EX branch taken; IF/ID and ID/EX flushed this edge.
- `mem_freeze` in 1 — memory stall; whole pipeline holds.
- `stat_clear` in 1 — synchronous clear of `stall_count`.
- `hazard` out 1 — stall request, combinational.
- `ex_wb_en`, `ex_dest`, `mem_wb_en`, `mem_dest` out 1/4/1/4 — shadow-slot contents, for debug.
- `stall_count` out `CNT_W` — saturating count of stall cycles.

## Operation
- Slot = {`wb_en`, `dest`, `mem_read`}. Bubble = all zero.
- `m(s)` = `s.wb_en` & (`src1`==`s.dest` | (`two_src` & `src2`==`s.dest`)).
- Raw hazard:
  - `FORWARDING`=0: `m(EX)` | `m(MEM)`.
  - `FORWARDING`=1: `m(EX)` & `EX.mem_read`.
- `hazard` = `id_valid` & !`branch_taken` & raw. A flushed instruction never stalls.
- Register r0..r15 all compared, including r15. There is no special zero register.
- Per rising edge, when `mem_freeze`=0:
  - MEM ← EX.
  - EX ← bubble if `hazard` | `branch_taken` | !`id_valid`; else {`id_wb_en`, `id_dest`, `id_mem_read`}.
- When `mem_freeze`=1: both slots hold; `hazard` still evaluates combinationally.
- `stall_count`:
  - `stat_clear` → 0. Clear wins over a simultaneous increment.
  - Otherwise, when `hazard` & !`mem_freeze`: +1, saturating at 2^`CNT_W`−1 (no wrap).
- Reset (async, `rst`=0): both slots bubble, `stall_count`=0. All outputs 0, `hazard`=0 (bubbles never match). Reset mid-stall drops the stall immediately.

## Timing
- `hazard`: zero latency, same cycle as the ID inputs. No registered path from inputs to `hazard`.
- Slot outputs are registered: an ID instruction accepted at edge N appears in EX after edge N and in MEM after edge N+1.
- `FORWARDING`=0, dependent instruction directly after a writer: stalls 2 cycles (writer in EX, then MEM).
- `FORWARDING`=1, load-use: stalls exactly 1 cycle. Non-load dependency: 0 cycles.
- `mem_freeze` stretches any stall by the freeze length. `stall_count` does not count frozen cycles.
- `branch_taken` and `hazard` in the same cycle: `hazard` forced 0; EX gets a bubble.

## Structure
- `REG_ADDRESS_LEN` comes from the shared defines file.
- Add `HAZ_SLOT_W` (=6) and a bubble-constant define there.
- One sub-module is natural: `sat_counter` (parameterised width, inc, clear, saturate). It is instantiated for `stall_count`.
- Slot registers and compare logic stay in `hazard_tracker`.

## Test plan
- Reset release, `id_valid`=0 for 3 cycles → `hazard`=0, slots 0, `stall_count`=0.
- `FORWARDING`=0: ADD r3 (wb_en, dest 3) then SUB with `src1`=3 → `hazard`=1 for 2 cycles, then 0; `stall_count`=2.
- `FORWARDING`=1: LDR r5 (`mem_read`) then ADD with `two_src`=1, `src2`=5 → `hazard`=1 for 1 cycle. With `two_src`=0 and `src1`=4 → `hazard`=0.
- Dependent pair with `branch_taken`=1 during the stall cycle → `hazard`=0 that cycle; EX slot is a bubble next cycle.
- Stall active, `mem_freeze`=1 for 3 cycles → `hazard` stays 1, slots frozen, `stall_count` unchanged. After release the stall completes normally.
- `CNT_W`=2, 5 stall cycles → count saturates at 3. `stat_clear` with a concurrent stall → 0. `rst` pulse mid-stall → `hazard` drops asynchronously.
